// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator and DEPTH-entry prefetch queue between instruction sram and decode.
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  output logic [DATA_W-1:0] imem_addr,
  output logic              imem_ren,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_pc_plus4
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]  DEPTH_X = (CNT_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_tag_pc;
  logic              r_inflight;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_q_pc    [DEPTH];
  logic [DATA_W-1:0] r_q_instr [DEPTH];

  logic              w_pop;
  logic              w_write;
  logic              w_credit;
  logic              w_issue;
  logic [CNT_W:0]    w_used;
  logic [CNT_W:0]    w_limit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready & ~redirect_valid;
  assign w_write   = r_inflight & ~redirect_valid;

  // The inflight read already owns a slot, so it is counted against capacity.
  assign w_used    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_limit   = DEPTH_X + {{CNT_W{1'b0}}, w_pop};
  assign w_credit  = (w_used < w_limit);
  assign w_issue   = enable & w_credit & ~redirect_valid & arst_n;

  assign imem_addr    = r_pc;
  assign imem_ren     = w_issue;
  assign out_instr    = r_q_instr[r_rd_ptr];
  assign out_pc       = r_q_pc[r_rd_ptr];
  assign out_pc_plus4 = out_pc + PC_STEP;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_pc       <= RESET_PC;
      r_tag_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_pc <= r_pc;
        r_pc     <= r_pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_write) begin
      r_q_pc[r_wr_ptr]    <= r_tag_pc;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue (DEPTH=4 and DEPTH=3 instances).
module tb_fetch_queue;

  logic clk;
  logic arst_n;

  logic        a_enable, a_imem_ren, a_redirect_valid, a_out_valid, a_out_ready;
  logic [31:0] a_imem_addr, a_imem_rdata, a_redirect_pc, a_out_instr, a_out_pc, a_out_plus4;
  logic        b_enable, b_imem_ren, b_redirect_valid, b_out_valid, b_out_ready;
  logic [31:0] b_imem_addr, b_imem_rdata, b_redirect_pc, b_out_instr, b_out_pc, b_out_plus4;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.DATA_W(32), .DEPTH(4)) dut_a (
    .clk(clk), .arst_n(arst_n), .enable(a_enable),
    .imem_addr(a_imem_addr), .imem_ren(a_imem_ren), .imem_rdata(a_imem_rdata),
    .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
    .out_pc(a_out_pc), .out_pc_plus4(a_out_plus4)
  );

  fetch_queue #(.DATA_W(32), .DEPTH(3)) dut_b (
    .clk(clk), .arst_n(arst_n), .enable(b_enable),
    .imem_addr(b_imem_addr), .imem_ren(b_imem_ren), .imem_rdata(b_imem_rdata),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .out_pc_plus4(b_out_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'h1000 + (addr >> 2);
  endfunction

  // Synchronous 1-cycle instruction sram models.
  always @(posedge clk) if (a_imem_ren) a_imem_rdata <= word_at(a_imem_addr);
  always @(posedge clk) if (b_imem_ren) b_imem_rdata <= word_at(b_imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    arst_n = 1'b0;
    a_enable = 0; a_out_ready = 0; a_redirect_valid = 0; a_redirect_pc = 0; a_imem_rdata = 0;
    b_enable = 0; b_out_ready = 0; b_redirect_valid = 0; b_redirect_pc = 0; b_imem_rdata = 0;

    #12;
    chk("rst_ren",   {31'b0, a_imem_ren}, 32'd0);
    chk("rst_addr",  a_imem_addr, 32'd0);
    chk("rst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_instr", a_out_instr, 32'd0);
    chk("rst_pc",    a_out_pc, 32'd0);
    chk("rst_plus4", a_out_plus4, 32'd4);
    arst_n = 1'b1;

    // Sequential stream, out_ready high
    tick();
    a_enable = 1; a_out_ready = 1; #1;
    chk("seq_ren0",  {31'b0, a_imem_ren}, 32'd1);
    chk("seq_addr0", a_imem_addr, 32'd0);
    tick(); #1;
    chk("seq_valid1", {31'b0, a_out_valid}, 32'd0);
    chk("seq_addr1",  a_imem_addr, 32'd4);
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("seq_valid", {31'b0, a_out_valid}, 32'd1);
      chk("seq_pc",    a_out_pc, 32'(4 * k));
      chk("seq_instr", a_out_instr, 32'h1000 + 32'(k));
      chk("seq_plus4", a_out_plus4, 32'(4 * k + 4));
      tick();
    end

    // Stall until 3 entries are queued with a read inflight, then redirect
    a_out_ready = 0;
    tick(); tick(); #1;
    chk("pre_rd_count",    {29'b0, dut_a.r_count}, 32'd3);
    chk("pre_rd_inflight", {31'b0, dut_a.r_inflight}, 32'd1);
    a_redirect_valid = 1; a_redirect_pc = 32'h200; #1;
    chk("rd_ren_r0", {31'b0, a_imem_ren}, 32'd0);
    tick();
    a_redirect_valid = 0; #1;
    chk("rd_valid_r1", {31'b0, a_out_valid}, 32'd0);
    chk("rd_addr_r1",  a_imem_addr, 32'h200);
    chk("rd_ren_r1",   {31'b0, a_imem_ren}, 32'd1);
    tick();
    a_enable = 0; #1;
    chk("rd_valid_r2", {31'b0, a_out_valid}, 32'd0);
    chk("en_ren_r2",   {31'b0, a_imem_ren}, 32'd0);
    chk("en_addr_r2",  a_imem_addr, 32'h204);
    chk("en_inflight", {31'b0, dut_a.r_inflight}, 32'd1);
    tick();
    a_out_ready = 1; #1;
    chk("rd_valid_r3", {31'b0, a_out_valid}, 32'd1);
    chk("rd_pc_r3",    a_out_pc, 32'h200);
    chk("rd_instr_r3", a_out_instr, 32'h1080);
    chk("rd_plus4_r3", a_out_plus4, 32'h204);
    chk("en_ren_r3",   {31'b0, a_imem_ren}, 32'd0);
    chk("en_addr_r3",  a_imem_addr, 32'h204);
    tick();
    a_enable = 1; #1;
    chk("en_valid_r4", {31'b0, a_out_valid}, 32'd0);
    chk("en_ren_r4",   {31'b0, a_imem_ren}, 32'd1);
    chk("en_addr_r4",  a_imem_addr, 32'h204);
    tick(); #1;
    chk("en_valid_r5", {31'b0, a_out_valid}, 32'd0);
    tick(); #1;
    chk("en_valid_r6", {31'b0, a_out_valid}, 32'd1);
    chk("en_pc_r6",    a_out_pc, 32'h204);
    chk("en_instr_r6", a_out_instr, 32'h1081);

    // Redirect to the top of the address space
    a_redirect_valid = 1; a_redirect_pc = 32'hFFFF_FFFC;
    tick();
    a_redirect_valid = 0; #1;
    chk("wrap_addr_x1", a_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_ren_x1",  {31'b0, a_imem_ren}, 32'd1);
    tick(); #1;
    chk("wrap_addr_x2",  a_imem_addr, 32'd0);
    chk("wrap_valid_x2", {31'b0, a_out_valid}, 32'd0);
    tick(); #1;
    chk("wrap_valid_x3", {31'b0, a_out_valid}, 32'd1);
    chk("wrap_pc_x3",    a_out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr_x3", a_out_instr, 32'h4000_0FFF);
    chk("wrap_plus4_x3", a_out_plus4, 32'd0);
    tick(); #1;
    chk("wrap_pc_x4",    a_out_pc, 32'd0);
    chk("wrap_instr_x4", a_out_instr, 32'h1000);
    tick();

    // Asynchronous reset mid-stream, observed before the next edge
    chk("mid_valid_pre", {31'b0, a_out_valid}, 32'd1);
    arst_n = 1'b0; #1;
    chk("arst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("arst_ren",   {31'b0, a_imem_ren}, 32'd0);
    chk("arst_addr",  a_imem_addr, 32'd0);
    chk("arst_pc",    a_out_pc, 32'd0);
    chk("arst_instr", a_out_instr, 32'd0);
    chk("arst_plus4", a_out_plus4, 32'd4);

    // Backpressure fill from reset with out_ready low
    a_out_ready = 0; arst_n = 1'b1; #1;
    chk("bp_ren0", {31'b0, a_imem_ren}, 32'd1);
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("bp_count",    {29'b0, dut_a.r_count}, 32'd4);
    chk("bp_pc",       a_imem_addr, 32'd16);
    chk("bp_inflight", {31'b0, dut_a.r_inflight}, 32'd0);
    chk("bp_ren_full", {31'b0, a_imem_ren}, 32'd0);
    chk("bp_head",     a_out_pc, 32'd0);
    tick(); #1;
    chk("bp_ren_hold", {31'b0, a_imem_ren}, 32'd0);
    chk("bp_count2",   {29'b0, dut_a.r_count}, 32'd4);
    a_out_ready = 1; #1;
    chk("bp_ren_pop",  {31'b0, a_imem_ren}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", {31'b0, a_out_valid}, 32'd1);
      chk("drain_pc",    a_out_pc, 32'(4 * k));
      chk("drain_instr", a_out_instr, 32'h1000 + 32'(k));
      tick(); #1;
    end
    a_enable = 0; a_out_ready = 0;

    // DEPTH=3 instance with out_ready toggling every cycle
    tick();
    b_enable = 1;
    n = 0;
    for (int c = 0; c < 120 && n < 20; c++) begin
      b_out_ready = c[0]; #1;
      chk("b_cnt_le3", {31'b0, (dut_b.r_count <= 2'd3)}, 32'd1);
      chk("b_ptr_le2", {31'b0, (dut_b.r_rd_ptr <= 2'd2) && (dut_b.r_wr_ptr <= 2'd2)}, 32'd1);
      if (b_out_valid) begin
        chk("b_seq_pc",    b_out_pc, 32'(4 * n));
        chk("b_seq_instr", b_out_instr, 32'h1000 + 32'(n));
        if (b_out_ready) n++;
      end
      tick();
    end
    chk("b_accepted", 32'(n), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the cpu. It replaces the single fetch pipeline register (instruction plus PC+4) with a PC generator and a DEPTH-entry prefetch queue. Decode sees a valid/ready interface and can stall. Branch, jump and other redirects flush the queue and restart fetch at a new address. The block sits between the instruction sram (synchronous, 1-cycle read) and the control/decode stage.

## Interface
- DATA_W, 32, width of PC, instruction and address buses
- DEPTH, 4, prefetch queue entries; legal values are DEPTH >= 2
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, PC increment per sequential fetch

Ports:
- clk  in  1  main clock, all state updates on the rising edge
- arst_n  in  1  asynchronous active-low reset
- enable  in  1  fetch enable; gates new instruction memory reads only
- imem_addr  out  DATA_W  instruction memory read address (= pc_q)
- imem_ren  out  1  instruction memory read strobe
- imem_rdata  in  DATA_W  instruction memory read data, valid the cycle after imem_ren
- redirect_valid  in  1  flush queue and restart fetch
- redirect_pc  in  DATA_W  restart address
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  DATA_W  head instruction
- out_pc  out  DATA_W  head instruction address
- out_pc_plus4  out  DATA_W  out_pc + PC_STEP, modulo 2^DATA_W (feeds branch unit as updated_pc)

## Operation
State:
- pc_q: the next fetch address.
- inflight: 1-bit flag with a tag_pc register.
- Queue: DEPTH entries of {pc, instr}, with rd_ptr, wr_ptr and count.
  - count is $clog2(DEPTH+1) bits wide.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.

Per-cycle rules:
- pop = out_valid & out_ready & ~redirect_valid.
- credit = (count + inflight) < (DEPTH + pop).
- issue = enable & credit & ~redirect_valid.
  - imem_ren = issue.
  - On issue: inflight <= 1, tag_pc <= pc_q, pc_q <= pc_q + PC_STEP (wraps modulo 2^DATA_W).
- A cycle with inflight = 1 and no redirect writes {tag_pc, imem_rdata} at wr_ptr and increments count.
  - inflight then clears unless a new issue happens in the same cycle.
- pop advances rd_ptr and decrements count.
  - Write and pop in the same cycle leave count unchanged.
- out_valid = (count != 0); out_instr and out_pc come from the rd_ptr entry.

Redirect (highest priority):
- pc_q <= redirect_pc.
- count, rd_ptr and wr_ptr go to 0.
- inflight clears; the returning read data is discarded.
- No issue and no pop that cycle.
- This applies regardless of enable.

Other conditions:
- enable low: no new reads. An inflight read still lands in the queue, and pops continue.
- Full (count == DEPTH): credit cannot be true with pop = 0, so there is no issue and no overflow.
- Empty: out_valid = 0 and out_ready is ignored.
- Credit counts inflight, so a write into a full queue is impossible by construction.

## Timing
Reset (arst_n low, asynchronous):
- pc_q = RESET_PC, count = 0, pointers = 0, inflight = 0.
- Queue storage = 0.
- Outputs: imem_ren = 0, imem_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, out_pc_plus4 = PC_STEP.
- Reset asserted mid-operation discards all entries and the inflight read immediately.

Latency and throughput:
- A read issued in cycle N (imem_ren high) returns data in N+1, which is written at the end of N+1.
- out_valid rises in N+2, so fetch-to-decode latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle with out_ready held high.

Redirect:
- redirect_valid asserted in cycle R causes the first read of redirect_pc in cycle R+1 (if enabled).
- That instruction appears at the output in R+3.
- out_valid is 0 during R+1 and R+2.

Paths:
- All outputs except imem_ren are driven from registers.
- imem_ren is combinational from enable, redirect_valid, out_ready and the state registers.

## Test plan
- Reset release, enable=1, out_ready=1, memory word i = 0x1000+i at address 4i:
  - out_valid first rises 2 cycles after the first imem_ren.
  - Outputs then come every cycle: out_pc 0,4,8,… and out_instr 0x1000,0x1001,… with out_pc_plus4 = out_pc+4.
- Backpressure, DEPTH=4, out_ready=0:
  - count reaches 4 with pc_q = 16 and inflight = 0.
  - imem_ren stays 0.
  - Raising out_ready then drains entries 0..3 in order with no loss or duplicates.
- Redirect to 0x200 while the queue holds 3 entries and a read is inflight:
  - The next cycle has out_valid = 0.
  - The next imem_addr is 0x200.
  - The first output after the flush is out_pc = 0x200; no stale instruction appears.
- enable dropped with a read inflight:
  - That instruction still enters the queue.
  - No further imem_ren until enable returns.
  - pc_q is held.
- Wrap with DEPTH=3 and out_ready toggling every cycle:
  - Run 20 instructions; the output sequence stays strictly sequential.
  - count never exceeds 3.
  - Pointers wrap 2 -> 0 correctly.
- Corner cases:
  - redirect_pc = 0xFFFFFFFC: the next fetch is at 0x00000000 and out_pc_plus4 = 0.
  - arst_n asserted mid-stream: all outputs go to their reset values asynchronously, before the next clock edge.
